// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder/subtractor that reuses one 4-bit ripple adder,
// processing one nibble per clock LSB first with the carry held in a register.

module FullAdder4bits_Structural (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       c_i,
    output logic [3:0] s_o,
    output logic       c_o
);
    logic [4:0] carry;

    assign carry[0] = c_i;

    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign s_o[i]       = a_i[i] ^ b_i[i] ^ carry[i];
        assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = carry[4];
endmodule

module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic             c_q, c_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d, ovf_q, ovf_d;

    logic [IW+1:0]    shamt;
    logic [3:0]       aSlice, bSlice, addSum;
    logic             addCout;
    logic [WIDTH-1:0] sMerged;

    assign shamt  = {idx_q, 2'b00};
    assign aSlice = 4'(a_q >> shamt);
    assign bSlice = 4'(b_q >> shamt);

    FullAdder4bits_Structural u_adder (
        .a_i (aSlice),
        .b_i (bSlice),
        .c_i (c_q),
        .s_o (addSum),
        .c_o (addCout)
    );

    // Partial result with the current slice already merged in, so the final
    // slice can be published in the same edge that leaves RUN.
    assign sMerged = (s_q & ~(WIDTH'(4'hF) << shamt)) | (WIDTH'(addSum) << shamt);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    c_d     = sub ? 1'b1 : carry_in;
                    s_d     = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                s_d = sMerged;
                c_d = addCout;
                if (idx_q == LAST) begin
                    state_d = DONE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    sum_d   = sMerged;
                    cout_d  = addCout;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sMerged[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;
endmodule
